// File: rtl/cordic_pkg.sv
// Shared constants, word widths, tag/result records and the CORDIC arctangent table
// used by the feeder and the pipelined rotator core.
package cordic_pkg;

  localparam int ANGLE_W  = 32;
  localparam int RES_W    = 32;
  localparam int CORE_LAT = 17;
  localparam int STAGES   = 16;
  localparam int GUARD    = 4;
  localparam int CORE_W   = ANGLE_W + GUARD + 2;

  localparam logic signed [ANGLE_W-1:0] K_Q16       = 32'sd39797;
  localparam logic signed [ANGLE_W-1:0] PI_Q16      = 32'sd205887;
  localparam logic signed [ANGLE_W-1:0] HALF_PI_Q16 = 32'sd102944;

  typedef struct packed {
    logic valid;
    logic neg;
    logic err;
  } tag_t;

  typedef struct packed {
    logic [RES_W-1:0] cos_v;
    logic [RES_W-1:0] sin_v;
    logic             err;
  } result_t;

  localparam int RESULT_W = $bits(result_t);

  // atan(2^-i) in radians, scaled by 2^(16+GUARD) to match the core's internal z
  function automatic logic signed [CORE_W-1:0] atan_q20(input int i);
    logic [19:0] v;
    v = '0;
    case (i)
      0:  v = 20'd823550;
      1:  v = 20'd486170;
      2:  v = 20'd256879;
      3:  v = 20'd130396;
      4:  v = 20'd65451;
      5:  v = 20'd32757;
      6:  v = 20'd16383;
      7:  v = 20'd8192;
      8:  v = 20'd4096;
      9:  v = 20'd2048;
      10: v = 20'd1024;
      11: v = 20'd512;
      12: v = 20'd256;
      13: v = 20'd128;
      14: v = 20'd64;
      15: v = 20'd32;
      default: v = '0;
    endcase
    return CORE_W'(v);
  endfunction

endpackage

// File: rtl/cordic_core.sv
// 16-stage pipelined CORDIC rotator (rotation mode) plus a rounding output register.
// Carries GUARD extra fraction bits internally; no reset, validity is tracked outside.
module cordic_core
  import cordic_pkg::*;
(
  input  logic                      clk,
  input  logic signed [ANGLE_W-1:0] x0,
  input  logic signed [ANGLE_W-1:0] y0,
  input  logic signed [ANGLE_W-1:0] z0,
  output logic signed [RES_W-1:0]   x_out,
  output logic signed [RES_W-1:0]   y_out
);

  localparam logic signed [CORE_W-1:0] RND = CORE_W'(1 << (GUARD - 1));

  logic signed [CORE_W-1:0] xi [STAGES];
  logic signed [CORE_W-1:0] yi [STAGES];
  logic signed [CORE_W-1:0] zi [STAGES];
  logic signed [CORE_W-1:0] xn [STAGES];
  logic signed [CORE_W-1:0] yn [STAGES];
  logic signed [CORE_W-1:0] zn [STAGES-1];
  logic signed [CORE_W-1:0] xs [STAGES];
  logic signed [CORE_W-1:0] ys [STAGES];
  logic signed [CORE_W-1:0] zs [STAGES-1];
  logic signed [CORE_W-1:0] xr;
  logic signed [CORE_W-1:0] yr;

  always_comb begin
    xi[0] = {{(CORE_W-ANGLE_W-GUARD){x0[ANGLE_W-1]}}, x0, {GUARD{1'b0}}};
    yi[0] = {{(CORE_W-ANGLE_W-GUARD){y0[ANGLE_W-1]}}, y0, {GUARD{1'b0}}};
    zi[0] = {{(CORE_W-ANGLE_W-GUARD){z0[ANGLE_W-1]}}, z0, {GUARD{1'b0}}};
    for (int i = 1; i < STAGES; i++) begin
      xi[i] = xs[i-1];
      yi[i] = ys[i-1];
      zi[i] = zs[i-1];
    end
    // Rotate toward z = 0; the last stage only needs the sign of its residual angle
    for (int i = 0; i < STAGES; i++) begin
      if (zi[i][CORE_W-1]) begin
        xn[i] = xi[i] + (yi[i] >>> i);
        yn[i] = yi[i] - (xi[i] >>> i);
      end else begin
        xn[i] = xi[i] - (yi[i] >>> i);
        yn[i] = yi[i] + (xi[i] >>> i);
      end
    end
    for (int i = 0; i < STAGES - 1; i++) begin
      zn[i] = zi[i][CORE_W-1] ? zi[i] + atan_q20(i) : zi[i] - atan_q20(i);
    end
    xr = xs[STAGES-1] + RND;
    yr = ys[STAGES-1] + RND;
  end

  always_ff @(posedge clk) begin
    xs    <= xn;
    ys    <= yn;
    zs    <= zn;
    x_out <= RES_W'(xr >>> GUARD);
    y_out <= RES_W'(yr >>> GUARD);
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; storage has no reset, only the
// pointers and occupancy do.
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_feeder.sv
// Front/back-end for the pipelined CORDIC: clamps and folds angles, tracks validity and
// quadrant sign alongside the core, and buffers results under a credit scheme.
module cordic_feeder
  import cordic_pkg::*;
#(
  parameter int FIFO_DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ANGLE_W-1:0] in_angle,
  output logic signed [ANGLE_W-1:0] core_x0,
  output logic signed [ANGLE_W-1:0] core_y0,
  output logic signed [ANGLE_W-1:0] core_z0,
  input  logic signed [RES_W-1:0]   core_X,
  input  logic signed [RES_W-1:0]   core_Y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [RES_W-1:0]   out_cos,
  output logic signed [RES_W-1:0]   out_sin,
  output logic                      out_err
);

  // Both sides use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; valid never waits on ready, and an offered result holds until taken.

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = CW + 1;

  logic                      accept;
  logic                      push;
  logic                      pop;
  logic signed [ANGLE_W-1:0] a_clamp;
  logic signed [ANGLE_W-1:0] z_fold;
  logic                      neg_c;
  logic                      err_c;
  tag_t [CORE_LAT:0]         tags;
  tag_t                      tail;
  logic [CW-1:0]             inflight;
  logic [CW-1:0]             fifo_count;
  logic [UW-1:0]             used;
  logic                      ready_en;
  logic                      fifo_full;
  logic                      fifo_empty;
  result_t                   push_data;
  result_t                   head;
  result_t                   last;
  result_t                   shown;

  assign accept = in_valid & in_ready;
  assign tail   = tags[CORE_LAT];
  assign push   = tail.valid;
  assign pop    = out_valid & out_ready;
  assign used   = {1'b0, inflight} + {1'b0, fifo_count};

  // Every accepted angle reserves a buffer slot, so the core's output is never refused
  assign in_ready = ready_en && (used < UW'(FIFO_DEPTH));

  always_comb begin
    a_clamp = in_angle;
    err_c   = 1'b0;
    if (in_angle > PI_Q16) begin
      a_clamp = PI_Q16;
      err_c   = 1'b1;
    end else if (in_angle < -PI_Q16) begin
      a_clamp = -PI_Q16;
      err_c   = 1'b1;
    end
    z_fold = a_clamp;
    neg_c  = 1'b0;
    if (a_clamp > HALF_PI_Q16) begin
      z_fold = a_clamp - PI_Q16;
      neg_c  = 1'b1;
    end else if (a_clamp < -HALF_PI_Q16) begin
      z_fold = a_clamp + PI_Q16;
      neg_c  = 1'b1;
    end
  end

  always_comb begin
    push_data.cos_v = tail.neg ? -core_X : core_X;
    push_data.sin_v = tail.neg ? -core_Y : core_Y;
    push_data.err   = tail.err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_x0  <= K_Q16;
      core_y0  <= '0;
      core_z0  <= '0;
      tags     <= '0;
      inflight <= '0;
      ready_en <= 1'b0;
      last     <= '0;
    end else begin
      ready_en <= 1'b1;
      tags     <= {tags[CORE_LAT-1:0], accept, neg_c, err_c};
      if (accept) begin
        core_x0 <= K_Q16;
        core_y0 <= '0;
        core_z0 <= z_fold;
      end
      case ({accept, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (pop) last <= head;
    end
  end

  sync_fifo #(
    .WIDTH (RESULT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // With an empty buffer the outputs keep showing the most recently taken result
  assign shown     = fifo_empty ? last : head;
  assign out_valid = !fifo_empty;
  assign out_cos   = shown.cos_v;
  assign out_sin   = shown.sin_v;
  assign out_err   = shown.err;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_cordic_feeder.sv
// Bench for cordic_feeder driving the real cordic_core; results are checked against
// cos/sin of the clamped input angle computed with real arithmetic.
module tb_cordic_feeder;

  localparam int TOL   = 8;
  localparam int PI_I  = 205887;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_angle;
  logic signed [31:0] core_x0, core_y0, core_z0;
  logic signed [31:0] core_X, core_Y;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_cos, out_sin;
  logic               out_err;

  int n_cmp     = 0;
  int n_fail    = 0;
  int n_pops    = 0;
  int n_accepts = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  cordic_feeder #(.FIFO_DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .core_x0   (core_x0),
    .core_y0   (core_y0),
    .core_z0   (core_z0),
    .core_X    (core_X),
    .core_Y    (core_Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin),
    .out_err   (out_err)
  );

  cordic_core u_core (
    .clk   (clk),
    .x0    (core_x0),
    .y0    (core_y0),
    .z0    (core_z0),
    .x_out (core_X),
    .y_out (core_Y)
  );

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: clamp to [-pi, pi] and evaluate cos/sin directly
  function automatic logic [64:0] model(input logic signed [31:0] a);
    real r;
    logic err;
    logic signed [31:0] c, s;
    err = 1'b0;
    r = $itor(a);
    if (a > 32'sd205887) begin r = 205887.0; err = 1'b1; end
    else if (a < -32'sd205887) begin r = -205887.0; err = 1'b1; end
    r = r / 65536.0;
    c = rnd($cos(r) * 65536.0);
    s = rnd($sin(r) * 65536.0);
    return {c, s, err};
  endfunction

  function automatic logic signed [31:0] rand_angle();
    logic signed [31:0] edges [8];
    edges = '{32'sd205887, -32'sd205887, 32'sd102944, -32'sd102944,
              32'sd102945, -32'sd102945, 32'sd0, 32'sd1};
    if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 7)];
    return $urandom_range(0, 2 * PI_I) - PI_I;
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge
  always @(negedge clk) begin : scoreboard
    logic [64:0] e;
    int dc, ds;
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        n_pops++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got cos=%0d sin=%0d err=%0b, required no result", out_cos, out_sin, out_err);
        end else begin
          e  = exp_q.pop_front();
          dc = int'(out_cos) - int'($signed(e[64:33]));
          ds = int'(out_sin) - int'($signed(e[32:1]));
          if (iabs(dc) > TOL || iabs(ds) > TOL || out_err !== e[0]) begin
            n_fail++;
            $display("FAIL scoreboard_result: got cos=%0d sin=%0d err=%0b, required cos=%0d sin=%0d err=%0b (+/-%0d)",
                     out_cos, out_sin, out_err, $signed(e[64:33]), $signed(e[32:1]), e[0], TOL);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_angle));
        n_accepts++;
      end
    end
  end

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d outstanding, out_valid=%0b, required 0 and 0", name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    n_cmp++; if (out_cos !== 32'sd0 || out_sin !== 32'sd0 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_data: got %0d/%0d/%0b required 0/0/0", out_cos, out_sin, out_err); end
    n_cmp++; if (core_x0 !== 32'sd39797 || core_y0 !== 32'sd0 || core_z0 !== 32'sd0) begin
      n_fail++; $display("FAIL reset_core_in: got %0d/%0d/%0d required 39797/0/0", core_x0, core_y0, core_z0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_single(input int angle, input int ec, input int es, input logic eerr, input string name);
    int lat;
    bit seen;
    lat = 0; seen = 0;
    in_angle = angle; in_valid = 1'b1; out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %0b required 1", name, in_ready); end
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == 1) in_valid = 1'b0;
      if (out_valid) begin
        seen = 1; lat = k;
        n_cmp++;
        if (iabs(int'(out_cos) - ec) > TOL || iabs(int'(out_sin) - es) > TOL || out_err !== eerr) begin
          n_fail++;
          $display("FAIL %s_value: got cos=%0d sin=%0d err=%0b required cos=%0d sin=%0d err=%0b",
                   name, out_cos, out_sin, out_err, ec, es, eerr);
        end
      end
    end
    n_cmp++;
    if (!seen || lat != 19) begin
      n_fail++; $display("FAIL %s_latency: got %0d cycles (seen=%0b) required 19", name, lat, seen);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_angles();
    test_single(0,       65536,  0,      1'b0, "angle_zero");
    test_single(102944,  0,      65536,  1'b0, "angle_half_pi");
    test_single(-51472,  46341,  -46341, 1'b0, "angle_neg_quarter_pi");
    test_single(205887,  -65536, 0,      1'b0, "angle_pi");
    test_single(300000,  -65536, 0,      1'b1, "angle_clamp_pos");
    test_single(-300000, -65536, 0,      1'b1, "angle_clamp_neg");
  endtask

  task automatic test_backpressure();
    int acc, pops0;
    logic [64:0] head0;
    acc = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_angle = rand_angle();
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (acc != 32) begin n_fail++; $display("FAIL bp_accepted: got %0d required 32", acc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %0b required 0", in_ready); end
    repeat (25) @(posedge clk);
    #1;
    head0 = {out_cos, out_sin, out_err};
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || {out_cos, out_sin, out_err} !== head0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: got valid=%0b head=%h ready=%0b required valid=1 head=%h ready=0",
               out_valid, {out_cos, out_sin, out_err}, in_ready, head0);
    end
    pops0 = n_pops;
    drain("bp");
    n_cmp++; if (n_pops - pops0 != 32) begin n_fail++; $display("FAIL bp_pop_count: got %0d required 32", n_pops - pops0); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %0b required 1", in_ready); end
  endtask

  task automatic test_random();
    int acc0, pops0;
    acc0 = n_accepts; pops0 = n_pops;
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      in_angle  = rand_angle();
      @(posedge clk); #1;
    end
    drain("random");
    n_cmp++;
    if (n_pops - pops0 != n_accepts - acc0 || n_accepts - acc0 < 100) begin
      n_fail++;
      $display("FAIL random_count: got %0d results for %0d accepts, required equal and at least 100", n_pops - pops0, n_accepts - acc0);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_angle = rand_angle();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %0b required 1", out_valid); end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_now: got valid=%0b ready=%0b required 0/0", out_valid, in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_cmp++; if (stale != 0) begin n_fail++; $display("FAIL mid_stale: got %0d stale cycles required 0", stale); end
    test_single(0, 65536, 0, 1'b0, "mid_first_new");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_angles();
    test_backpressure();
    test_random();
    test_reset_mid();
    drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
